// File: rtl/io_arb_pkg.sv
// Shared types for the I/O-bridge round-robin arbiter.
package io_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_NACK = 2'd2
    } state_e;

    localparam logic [7:0] ERR_SAT = 8'hFF;

endpackage

// File: rtl/io_rr_pick.sv
// Combinational round-robin picker: first valid request at or after ptr_i, wrapping modulo NREQ.
module io_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   idx_o,
    output logic            any_o
);

    logic [PW-1:0] cand;

    always_comb begin
        idx_o = '0;
        cand  = '0;
        gnt_o = '0;
        any_o = |req_i;
        // Walk from the farthest offset down so the nearest valid candidate wins.
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = PW'((int'(ptr_i) + i) % NREQ);
            if (req_i[cand]) idx_o = cand;
        end
        if (any_o) gnt_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone-classic master port among NREQ requesters,
// with per-transaction timeout that turns a missing device ack into an error.
module io_bus_arbiter
    import io_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255,
    parameter int CNTW    = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NREQ-1:0]    s_cyc_i,
    input  logic [NREQ-1:0]    s_stb_i,
    input  logic [NREQ-1:0]    s_we_i,
    input  logic [4*NREQ-1:0]  s_sel_i,
    input  logic [32*NREQ-1:0] s_adr_i,
    input  logic [32*NREQ-1:0] s_dat_i,
    output logic [NREQ-1:0]    s_ack_o,
    output logic [NREQ-1:0]    s_err_o,
    output logic [31:0]        s_dat_o,
    output logic               m_cyc_o,
    output logic               m_stb_o,
    input  logic               m_ack_i,
    output logic               m_we_o,
    output logic [3:0]         m_sel_o,
    output logic [31:0]        m_adr_o,
    output logic [31:0]        m_dat_o,
    input  logic [31:0]        m_dat_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [7:0]         err_cnt_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e            state_q;
    logic [PW-1:0]     ptr_q, idx_q, ptr_d;
    logic [CNTW-1:0]   tocnt_q;
    logic [NREQ-1:0]   gnt_q, ack_q, err_q;
    logic [31:0]       sdat_q, madr_q, mdat_q;
    logic              mcyc_q, mstb_q, mwe_q;
    logic [3:0]        msel_q;
    logic [7:0]        errcnt_q;

    logic [NREQ-1:0]   req_v, pick_gnt;
    logic [PW-1:0]     pick_idx;
    logic              pick_any;

    assign req_v = s_cyc_i & s_stb_i;

    io_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req_i (req_v),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Search restarts just past whoever was served last.
    assign ptr_d = (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + PW'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            tocnt_q  <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            err_q    <= '0;
            sdat_q   <= '0;
            mcyc_q   <= 1'b0;
            mstb_q   <= 1'b0;
            mwe_q    <= 1'b0;
            msel_q   <= '0;
            madr_q   <= '0;
            mdat_q   <= '0;
            errcnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!m_ack_i && pick_any) begin
                        gnt_q   <= pick_gnt;
                        idx_q   <= pick_idx;
                        mcyc_q  <= 1'b1;
                        mstb_q  <= 1'b1;
                        mwe_q   <= s_we_i[pick_idx];
                        msel_q  <= s_sel_i[4*pick_idx +: 4];
                        madr_q  <= s_adr_i[32*pick_idx +: 32];
                        mdat_q  <= s_dat_i[32*pick_idx +: 32];
                        tocnt_q <= '0;
                        state_q <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (m_ack_i) begin
                        ack_q   <= gnt_q;
                        sdat_q  <= m_dat_i;
                        mcyc_q  <= 1'b0;
                        mstb_q  <= 1'b0;
                        mwe_q   <= 1'b0;
                        state_q <= WAIT_NACK;
                    end else if (!s_cyc_i[idx_q]) begin
                        mcyc_q  <= 1'b0;
                        mstb_q  <= 1'b0;
                        mwe_q   <= 1'b0;
                        gnt_q   <= '0;
                        ptr_q   <= ptr_d;
                        state_q <= IDLE;
                    end else if (tocnt_q == CNTW'(TIMEOUT - 1)) begin
                        err_q   <= gnt_q;
                        mcyc_q  <= 1'b0;
                        mstb_q  <= 1'b0;
                        mwe_q   <= 1'b0;
                        if (errcnt_q != ERR_SAT) errcnt_q <= errcnt_q + 8'd1;
                        state_q <= WAIT_NACK;
                    end else begin
                        tocnt_q <= tocnt_q + CNTW'(1);
                    end
                end
                WAIT_NACK: begin
                    if (!s_stb_i[idx_q]) begin
                        ack_q   <= '0;
                        err_q   <= '0;
                        sdat_q  <= '0;
                        ptr_q   <= ptr_d;
                        gnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    mcyc_q  <= 1'b0;
                    mstb_q  <= 1'b0;
                    mwe_q   <= 1'b0;
                    ack_q   <= '0;
                    err_q   <= '0;
                    gnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s_ack_o   = ack_q;
    assign s_err_o   = err_q;
    assign s_dat_o   = sdat_q;
    assign m_cyc_o   = mcyc_q;
    assign m_stb_o   = mstb_q;
    assign m_we_o    = mwe_q;
    assign m_sel_o   = msel_q;
    assign m_adr_o   = madr_q;
    assign m_dat_o   = mdat_q;
    assign gnt_o     = gnt_q;
    assign err_cnt_o = errcnt_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: directed scenarios plus randomized traffic
// checked against a pending-set round-robin model.
module tb_io_bus_arbiter;

    localparam int NREQ = 4;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0, rst = 1'b0;
    logic [NREQ-1:0] s_cyc, s_stb, s_we;
    logic [4*NREQ-1:0] s_sel;
    logic [32*NREQ-1:0] s_adr, s_dat;
    logic [NREQ-1:0] s_ack, s_err, gnt;
    logic [31:0] s_dato, m_adr, m_dato, m_dati;
    logic m_cyc, m_stb, m_ack, m_we;
    logic [3:0] m_sel;
    logic [7:0] err_cnt;

    int tests_run = 0, fails = 0;

    io_bus_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .CNTW(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .s_cyc_i(s_cyc), .s_stb_i(s_stb), .s_we_i(s_we), .s_sel_i(s_sel),
        .s_adr_i(s_adr), .s_dat_i(s_dat),
        .s_ack_o(s_ack), .s_err_o(s_err), .s_dat_o(s_dato),
        .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_ack_i(m_ack), .m_we_o(m_we),
        .m_sel_o(m_sel), .m_adr_o(m_adr), .m_dat_o(m_dato), .m_dat_i(m_dati),
        .gnt_o(gnt), .err_cnt_o(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic we, input logic [3:0] sel,
                           input logic [31:0] adr, input logic [31:0] dat);
        s_we[n] = we;
        s_sel[4*n +: 4] = sel;
        s_adr[32*n +: 32] = adr;
        s_dat[32*n +: 32] = dat;
        s_cyc[n] = 1'b1;
        s_stb[n] = 1'b1;
    endtask

    task automatic drop_req(input int n);
        s_cyc[n] = 1'b0;
        s_stb[n] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_cyc = '0; s_stb = '0; s_we = '0; s_sel = '0; s_adr = '0; s_dat = '0;
        m_ack = 1'b0; m_dati = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_cyc = '0; s_stb = '0; s_we = '0; s_sel = '0; s_adr = '0; s_dat = '0;
        m_ack = 1'b0; m_dati = '0;
        set_req(0, 1'b1, 4'hF, 32'h1111_0000, 32'hAAAA_5555);
        tick(); tick();
        tests_run++;
        if ({m_cyc, m_stb, m_we, m_sel, m_adr, m_dato, gnt, s_ack, s_err, s_dato, err_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got cyc=%b stb=%b gnt=%b ack=%b err=%b cnt=%0d adr=%h exp all zero",
                     m_cyc, m_stb, gnt, s_ack, s_err, err_cnt, m_adr);
        end
        drop_req(0);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read();
        do_reset();
        set_req(2, 1'b0, 4'hF, 32'hFD00_0010, 32'h0);
        tick();
        tests_run++;
        if ({m_stb, m_cyc, gnt, m_adr, m_we} !== {1'b1, 1'b1, 4'b0100, 32'hFD00_0010, 1'b0}) begin
            fails++;
            $display("FAIL read_grant got stb=%b gnt=%b adr=%h we=%b exp stb=1 gnt=0100 adr=fd000010 we=0",
                     m_stb, gnt, m_adr, m_we);
        end
        tick(); tick();
        m_ack = 1'b1; m_dati = 32'h1234_5678;
        tick();
        m_ack = 1'b0;
        tests_run++;
        if ({s_ack, s_err, s_dato, m_cyc, m_stb} !== {4'b0100, 4'b0000, 32'h1234_5678, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL read_ack got ack=%b err=%b dat=%h cyc=%b exp ack=0100 err=0000 dat=12345678 cyc=0",
                     s_ack, s_err, s_dato, m_cyc);
        end
        tick();
        tests_run++;
        if (s_ack !== 4'b0100) begin
            fails++;
            $display("FAIL read_ack_hold got ack=%b exp 0100", s_ack);
        end
        drop_req(2);
        tick();
        tests_run++;
        if ({s_ack, s_dato, gnt} !== '0) begin
            fails++;
            $display("FAIL read_ack_clear got ack=%b dat=%h gnt=%b exp zeros", s_ack, s_dato, gnt);
        end
        set_req(0, 1'b0, 4'hF, 32'h0000_0A00, 32'h0);
        set_req(3, 1'b0, 4'hF, 32'h0000_0A03, 32'h0);
        tick();
        tests_run++;
        if ({gnt, m_adr} !== {4'b1000, 32'h0000_0A03}) begin
            fails++;
            $display("FAIL read_next_ptr got gnt=%b adr=%h exp gnt=1000 adr=00000a03", gnt, m_adr);
        end
    endtask

    task automatic test_rr_all();
        int exp;
        do_reset();
        for (int n = 0; n < NREQ; n++) set_req(n, 1'b0, 4'hF, 32'h5000_0000 + n, 32'h0);
        exp = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            tests_run++;
            if ({gnt, m_adr} !== {4'(1 << exp), 32'h5000_0000 + exp}) begin
                fails++;
                $display("FAIL rr_grant k=%0d got gnt=%b adr=%h exp gnt=%b", k, gnt, m_adr, 4'(1 << exp));
            end
            m_ack = 1'b1; m_dati = 32'hC0DE_0000 + k;
            tick();
            m_ack = 1'b0;
            tests_run++;
            if ({s_ack, s_dato} !== {4'(1 << exp), 32'hC0DE_0000 + k}) begin
                fails++;
                $display("FAIL rr_ack k=%0d got ack=%b dat=%h exp ack=%b", k, s_ack, s_dato, 4'(1 << exp));
            end
            drop_req(exp);
            tick();
            tests_run++;
            if (s_ack !== '0) begin
                fails++;
                $display("FAIL rr_single_ack k=%0d got ack=%b exp 0000", k, s_ack);
            end
            set_req(exp, 1'b0, 4'hF, 32'h5000_0000 + exp, 32'h0);
            exp = (exp + 1) % NREQ;
        end
    endtask

    task automatic test_timeout();
        int cyc;
        int bad;
        do_reset();
        set_req(1, 1'b1, 4'b0011, 32'h0000_1000, 32'hDEAD_BEEF);
        tick();
        tests_run++;
        if ({gnt, m_we, m_sel, m_dato} !== {4'b0010, 1'b1, 4'b0011, 32'hDEAD_BEEF}) begin
            fails++;
            $display("FAIL to_write_fields got gnt=%b we=%b sel=%b dat=%h", gnt, m_we, m_sel, m_dato);
        end
        cyc = 0;
        while (s_err === '0 && cyc < 40) begin
            tick();
            cyc++;
        end
        tests_run++;
        if (cyc !== TIMEOUT) begin
            fails++;
            $display("FAIL to_latency got %0d cycles exp %0d", cyc, TIMEOUT);
        end
        tests_run++;
        if ({s_err, s_ack, m_cyc, err_cnt} !== {4'b0010, 4'b0000, 1'b0, 8'd1}) begin
            fails++;
            $display("FAIL to_err got err=%b ack=%b cyc=%b cnt=%0d exp err=0010 ack=0000 cyc=0 cnt=1",
                     s_err, s_ack, m_cyc, err_cnt);
        end
        drop_req(1);
        tick();
        tests_run++;
        if (s_err !== '0) begin
            fails++;
            $display("FAIL to_err_clear got err=%b exp 0000", s_err);
        end
        bad = 0;
        for (int rep = 2; rep <= 300; rep++) begin
            set_req(1, 1'b1, 4'b0011, 32'h0000_1000, 32'hDEAD_BEEF);
            tick();
            cyc = 0;
            while (s_err === '0 && cyc < 40) begin
                tick();
                cyc++;
            end
            if (cyc != TIMEOUT || err_cnt !== 8'((rep > 255) ? 255 : rep)) bad++;
            drop_req(1);
            tick();
        end
        tests_run++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL to_repeat got %0d bad repetitions exp 0", bad);
        end
        tests_run++;
        if (err_cnt !== 8'd255) begin
            fails++;
            $display("FAIL to_saturate got cnt=%0d exp 255", err_cnt);
        end
    endtask

    task automatic test_abort();
        do_reset();
        set_req(0, 1'b0, 4'hF, 32'h0000_0B00, 32'h0);
        set_req(3, 1'b0, 4'hF, 32'h0000_0B03, 32'h0);
        tick();
        tests_run++;
        if (gnt !== 4'b0001) begin
            fails++;
            $display("FAIL abort_grant got gnt=%b exp 0001", gnt);
        end
        tick(); tick();
        drop_req(0);
        tick();
        tests_run++;
        if ({m_cyc, m_stb, gnt, s_ack, s_err} !== '0) begin
            fails++;
            $display("FAIL abort_release got cyc=%b stb=%b gnt=%b ack=%b err=%b exp zeros",
                     m_cyc, m_stb, gnt, s_ack, s_err);
        end
        tick();
        tests_run++;
        if ({gnt, m_adr, m_stb} !== {4'b1000, 32'h0000_0B03, 1'b1}) begin
            fails++;
            $display("FAIL abort_next got gnt=%b adr=%h stb=%b exp gnt=1000 adr=00000b03 stb=1", gnt, m_adr, m_stb);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(1, 1'b0, 4'hF, 32'h0000_0C01, 32'h0);
        tick(); tick();
        tests_run++;
        if ({m_cyc, gnt} !== {1'b1, 4'b0010}) begin
            fails++;
            $display("FAIL rmid_active got cyc=%b gnt=%b exp cyc=1 gnt=0010", m_cyc, gnt);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if ({m_cyc, m_stb, gnt, s_ack, s_err, m_adr} !== '0) begin
            fails++;
            $display("FAIL rmid_async got cyc=%b stb=%b gnt=%b ack=%b adr=%h exp zeros", m_cyc, m_stb, gnt, s_ack, m_adr);
        end
        #1;
        rst = 1'b0;
        tick();
        tests_run++;
        if ({gnt, m_stb} !== {4'b0010, 1'b1}) begin
            fails++;
            $display("FAIL rmid_regrant got gnt=%b stb=%b exp gnt=0010 stb=1", gnt, m_stb);
        end
        m_ack = 1'b1; m_dati = 32'h0BAD_F00D;
        tick();
        m_ack = 1'b0;
        tests_run++;
        if ({s_ack, s_dato} !== {4'b0010, 32'h0BAD_F00D}) begin
            fails++;
            $display("FAIL rmid_ack got ack=%b dat=%h exp ack=0010 dat=0badf00d", s_ack, s_dato);
        end
        drop_req(1);
        tick();
    endtask

    task automatic test_ack_stuck();
        do_reset();
        m_ack = 1'b1;
        set_req(0, 1'b0, 4'hF, 32'h0000_0D00, 32'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            tests_run++;
            if ({m_stb, gnt} !== '0) begin
                fails++;
                $display("FAIL stuck_block k=%0d got stb=%b gnt=%b exp stb=0 gnt=0000", k, m_stb, gnt);
            end
        end
        m_ack = 1'b0;
        tick();
        tests_run++;
        if ({m_stb, gnt} !== {1'b1, 4'b0001}) begin
            fails++;
            $display("FAIL stuck_release got stb=%b gnt=%b exp stb=1 gnt=0001", m_stb, gnt);
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] pending;
        logic [31:0] adr_m [NREQ];
        logic [31:0] dat_m [NREQ];
        logic [3:0]  sel_m [NREQ];
        logic        we_m  [NREQ];
        logic [31:0] rd;
        int ptr_m, g, d;
        do_reset();
        pending = '0;
        ptr_m = 0;
        for (int t = 0; t < 60; t++) begin
            for (int n = 0; n < NREQ; n++) begin
                if (!pending[n] && ($urandom_range(0, 2) == 0 || (pending == '0 && n == NREQ - 1))) begin
                    adr_m[n] = $urandom; dat_m[n] = $urandom;
                    sel_m[n] = 4'($urandom); we_m[n] = 1'($urandom);
                    set_req(n, we_m[n], sel_m[n], adr_m[n], dat_m[n]);
                    pending[n] = 1'b1;
                end
            end
            tick();
            g = -1;
            for (int k = NREQ - 1; k >= 0; k--)
                if (pending[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
            tests_run++;
            if (g < 0 || {gnt, m_stb, m_adr, m_we, m_sel, m_dato} !==
                         {4'(1 << g), 1'b1, adr_m[g], we_m[g], sel_m[g], dat_m[g]}) begin
                fails++;
                $display("FAIL rnd_grant t=%0d got gnt=%b adr=%h exp gnt=%b adr=%h", t, gnt, m_adr, 4'(1 << g), adr_m[g]);
            end
            d = $urandom_range(0, 3);
            for (int w = 0; w < d; w++) begin
                for (int n = 0; n < NREQ; n++) begin
                    if (!pending[n] && $urandom_range(0, 3) == 0) begin
                        adr_m[n] = $urandom; dat_m[n] = $urandom;
                        sel_m[n] = 4'($urandom); we_m[n] = 1'($urandom);
                        set_req(n, we_m[n], sel_m[n], adr_m[n], dat_m[n]);
                        pending[n] = 1'b1;
                    end
                end
                tick();
                tests_run++;
                if ({s_ack, s_err, m_stb} !== {8'h00, 1'b1}) begin
                    fails++;
                    $display("FAIL rnd_wait t=%0d got ack=%b err=%b stb=%b exp ack=0000 err=0000 stb=1", t, s_ack, s_err, m_stb);
                end
            end
            rd = $urandom;
            m_ack = 1'b1; m_dati = rd;
            tick();
            m_ack = 1'b0;
            tests_run++;
            if ({s_ack, s_err, s_dato} !== {4'(1 << g), 4'b0000, rd}) begin
                fails++;
                $display("FAIL rnd_ack t=%0d got ack=%b err=%b dat=%h exp ack=%b dat=%h", t, s_ack, s_err, s_dato, 4'(1 << g), rd);
            end
            drop_req(g);
            pending[g] = 1'b0;
            tick();
            tests_run++;
            if ({s_ack, gnt} !== '0) begin
                fails++;
                $display("FAIL rnd_idle t=%0d got ack=%b gnt=%b exp zeros", t, s_ack, gnt);
            end
            ptr_m = (g + 1) % NREQ;
        end
    endtask

    initial begin
        s_cyc = '0; s_stb = '0; s_we = '0; s_sel = '0; s_adr = '0; s_dat = '0;
        m_ack = 1'b0; m_dati = '0;
        test_reset();
        test_read();
        test_rr_all();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_ack_stuck();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
